// File: rtl/pipe_queue_pkg.sv
// Shared definitions for the pipe_queue elastic buffer: default sizing and
// the default payload layout (PC / NNPC / instruction, 32 bits each).
package pipe_queue_pkg;

  localparam int unsigned PQ_DEFAULT_DEPTH  = 4;
  localparam int unsigned PQ_DEFAULT_DATA_W = 96;

  // Default payload field offsets
  localparam int unsigned PQ_FIELD_W  = 32;
  localparam int unsigned PQ_PC_LSB   = 64;
  localparam int unsigned PQ_NNPC_LSB = 32;
  localparam int unsigned PQ_INST_LSB = 0;

  // Default payload packing, MSB first: pc, nnpc, inst
  typedef struct packed {
    logic [PQ_FIELD_W-1:0] pc;
    logic [PQ_FIELD_W-1:0] nnpc;
    logic [PQ_FIELD_W-1:0] inst;
  } pq_payload_t;

endpackage

// File: rtl/pipe_queue_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are not reset; pointers and count in
// the parent define which entries are live.
module pipe_queue_mem
  import pipe_queue_pkg::*;
#(
  parameter int unsigned DATA_W = PQ_DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = PQ_DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_queue.sv
// Elastic buffer between two pipeline stages using valid/allowin handshakes.
// Holds up to DEPTH payloads in strict FIFO order, flushes in one cycle and
// exports its occupancy. up_allowin_out depends only on registered state.
// Optional macro PIPE_QUEUE_BYPASS_EN: an empty queue passes an accepted
// payload straight through in the same cycle without storing it.
module pipe_queue
  import pipe_queue_pkg::*;
#(
  parameter int unsigned DATA_W = PQ_DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = PQ_DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_in,
  input  logic                          up_valid_in,
  input  logic [DATA_W-1:0]             up_data_in,
  output logic                          up_allowin_out,
  output logic                          dn_valid_out,
  output logic [DATA_W-1:0]             dn_data_out,
  input  logic                          dn_allowin_in,
  output logic [$clog2(DEPTH+1)-1:0]    count_out,
  output logic                          full_out,
  output logic                          empty_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic              full_q, empty_q;
  logic              push, pop;
  logic [DATA_W-1:0] head_data;

  // Handshake qualification and output selection
`ifdef PIPE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass       = empty_q & up_valid_in & dn_allowin_in & ~flush_in;
  assign push         = up_valid_in & ~full_q & ~flush_in & ~bypass;
  assign dn_valid_out = ~empty_q | bypass;
  assign dn_data_out  = bypass ? up_data_in : head_data;
`else
  assign push         = up_valid_in & ~full_q & ~flush_in;
  assign dn_valid_out = ~empty_q;
  assign dn_data_out  = head_data;
`endif

  // Pop only from real entries so a bypassed beat never touches the count
  assign pop = ~empty_q & dn_allowin_in & ~flush_in;

  assign up_allowin_out = ~full_q;
  assign count_out      = count_q;
  assign full_out       = full_q;
  assign empty_out      = empty_q;

  // Next pointer/count; flush overrides push and pop
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count_q;
    if (flush_in) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
      if (push && !pop)      count_n = count_q + CNT_W'(1);
      else if (pop && !push) count_n = count_q - CNT_W'(1);
    end
  end

  // Pointer, count and occupancy-flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      count_q <= count_n;
      full_q  <= (count_n == CNT_W'(DEPTH));
      empty_q <= (count_n == '0);
    end
  end

  pipe_queue_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (up_data_in),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

endmodule
